// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch FIFO between the PC register and decode.
// Keeps one memory request outstanding at most and discards queued and in-flight fetches on redirect.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic        FlushD,
  input  logic        StallD,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic        StallF,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] head, tail, head_nxt;
  logic [AW:0] count, occ;
  logic [31:0] req_pc;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc4_mem [DEPTH];
  logic push, pop, issue;
  assign ValidD = count != '0;
  assign imemAddr = PCF;
  assign imemReq = issue & rst_n;
  assign StallF = ~rst_n | ~(issue | FlushD);
  always_comb begin
    push = imemAck & (state == WAIT) & ~FlushD;
    pop = ValidD & ~StallD & ~FlushD;
    occ = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    issue = ~FlushD & (occ < (AW+1)'(DEPTH)) & ((state == IDLE) | ((state == WAIT) & imemAck));
    state_nxt = issue ? WAIT :
                (state == IDLE) ? IDLE :
                imemAck ? IDLE :
                ((state == WAIT) & ~FlushD) ? WAIT : DISCARD;
    head_nxt = FlushD ? tail : head + AW'(pop);
  end
  // Head outputs are registered so they hold the last head value while empty;
  // an entry pushed straight into the new head slot bypasses the array.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      head <= '0;
      tail <= '0;
      req_pc <= '0;
      InstrD <= '0;
      PCPlus4D <= '0;
    end else begin
      state <= state_nxt;
      count <= FlushD ? '0 : occ;
      head <= head_nxt;
      if (push) tail <= tail + AW'(1);
      if (issue) req_pc <= PCF;
      if (!FlushD && occ != '0) begin
        InstrD <= (push && head_nxt == tail) ? imemRdata : instr_mem[head_nxt];
        PCPlus4D <= (push && head_nxt == tail) ? req_pc + 32'd4 : pc4_mem[head_nxt];
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      instr_mem[tail] <= imemRdata;
      pc4_mem[tail] <= req_pc + 32'd4;
    end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch buffer between the PC register and the decode stage. Each cycle it has space, it issues the current fetch PC to instruction memory and drives `StallF` low so the PC register advances. It queues the returned instructions with their PC+4 in a small FIFO and presents them to decode with a valid flag. On a redirect it discards all queued and in-flight fetches.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PCF`  in  32  current fetch PC from the PC register.
- `FlushD`  in  1  redirect (branch or jump taken); discard buffer and in-flight fetch.
- `StallD`  in  1  decode cannot accept an instruction this cycle.
- `imemAck`  in  1  instruction memory returns data for the outstanding request.
- `imemRdata`  in  32  instruction word; valid when `imemAck`=1.
- `imemReq`  out  1  request strobe; combinational; memory accepts it unconditionally.
- `imemAddr`  out  32  request address; equals `PCF`.
- `StallF`  out  1  hold the PC register; combinational.
- `ValidD`  out  1  FIFO head holds a valid instruction.
- `InstrD`  out  32  instruction at the FIFO head.
- `PCPlus4D`  out  32  PC of the head instruction plus 4.

## Operation
- State register has three states.
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its PC is held in `reqPC`.
  - DISCARD: one request outstanding whose data must be dropped.
- FIFO holds `{instr, pc+4}` with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Per-cycle events:
  - `push` = `imemAck` & state==WAIT & !`FlushD`.
  - `pop` = `ValidD` & !`StallD` & !`FlushD`.
  - Push and pop in the same cycle are both performed; `count` is unchanged.
  - `occ` = `count` + `push` − `pop`.
- Issue condition: `issue` = !`FlushD` & `occ` < DEPTH & (state==IDLE | (state==WAIT & `imemAck`)).
  - `imemReq` = `issue`.
  - On issue, `reqPC` ← `PCF` and next state is WAIT.
- `StallF` = !(`issue` | `FlushD`). During a flush, `StallF` is low so the PC register loads the redirect target.
- Transitions when `FlushD`=0:
  - IDLE → WAIT on issue; otherwise stay in IDLE.
  - WAIT with no ack → WAIT.
  - WAIT with ack → WAIT if issuing, else IDLE.
  - DISCARD with no ack → DISCARD.
  - DISCARD with ack → IDLE; the data is dropped and no issue occurs that cycle.
- Transitions when `FlushD`=1:
  - FIFO is emptied: `count` ← 0, head ← tail.
  - WAIT with no ack → DISCARD.
  - WAIT with ack → IDLE; the data is dropped.
  - DISCARD stays DISCARD unless acked, then → IDLE.
  - IDLE → IDLE.
- `imemAck` while in IDLE is ignored; it is a protocol violation and is not counted.
- Arithmetic: `PCPlus4D` = `reqPC` + 4 computed at push, modulo 2^32; no overflow flag.

## Timing
- Reset (asynchronous on `rst_n` low):
  - state=IDLE, `count`=0, pointers=0, `reqPC`=0.
  - `ValidD`=0, `InstrD`=0, `PCPlus4D`=0.
  - `imemReq` is forced to 0 and `StallF` to 1 while `rst_n`=0.
  - Deasserting reset mid-request drops that request; a late ack is ignored because state is IDLE.
- Latency with single-cycle memory: request in cycle n, ack in cycle n+1, `ValidD`/`InstrD` visible in cycle n+2.
- Throughput is one instruction per cycle with single-cycle memory and no decode stall.
- Ack arrives 1 or more cycles after a request; at most one request is outstanding.
- Full: when `occ`=DEPTH, no issue and `StallF`=1. A pop in the same cycle frees a slot for an issue that cycle.
- Empty: `ValidD`=0, and `InstrD`/`PCPlus4D` hold their previous head value. Decode must qualify on `ValidD`.
- Flush takes effect at the next edge: `ValidD`=0 in the cycle after `FlushD`.

## Test plan
- **Reset then stream:** release reset with PCF=0x00400020 and 1-cycle memory returning PC-derived words.
  - `imemReq`=1 in the first cycle.
  - `ValidD`=1 two cycles later with `PCPlus4D`=0x00400024.
  - Thereafter one instruction per cycle with PCs incrementing by 4.
- **Fill to full:** hold `StallD`=1 with DEPTH=4.
  - Exactly 4 pushes, then `StallF`=1 and `imemReq`=0.
  - Drop `StallD` for one cycle: one pop and one issue occur in that same cycle.
- **Flush with outstanding request:** 3-cycle memory latency; assert `FlushD` in the cycle after issue.
  - State goes to DISCARD and the returned word is dropped.
  - The next `imemReq` carries the target PC (e.g. 0x00400100).
  - First `ValidD` has `PCPlus4D`=0x00400104.
- **Flush coincident with ack:** data is not pushed, state=IDLE, and a new issue occurs the following cycle.
- **Simultaneous push/pop at count=DEPTH−1:** `count` stays 3 and FIFO order is preserved, including across pointer wrap after 10 or more entries.
- **Asynchronous reset mid-WAIT:** `ValidD`, `count` and `imemReq` go to 0 without waiting for a clock edge, and a subsequent stray ack is ignored.
